// File: rtl/gauss_writeback.sv
// gauss_writeback
//   Downstream stage of the Gaussian block. Accepts one 7-pixel smoothed
//   column per handshake into a 2-entry buffer. Each column is written to
//   SRAM as seven byte writes at raster addresses of the output image.
//   Column/stripe position is tracked across the frame, and frame_done
//   pulses after the last byte of the last stripe has been accepted.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   gauss_valid  gauss_in holds a valid column
//   gauss_in     7 bytes, index k = row offset within the stripe
//   gauss_ready  column buffer can accept (registered count < 2)
//   sram_wr_en   write request
//   sram_addr    write address (0 while not writing)
//   sram_wdata   write byte    (0 while not writing)
//   sram_wr_ack  SRAM accepted the current write this cycle
//   frame_done   one-cycle pulse, whole frame written
module gauss_writeback #(
   parameter int unsigned       ADDR_W      = 16,
   parameter int unsigned       OUT_COLS    = 254,
   parameter int unsigned       OUT_STRIPES = 36,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h8000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              gauss_valid,
   input  logic [7:0]        gauss_in [0:6],
   output logic              gauss_ready,
   output logic              sram_wr_en,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [7:0]        sram_wdata,
   input  logic              sram_wr_ack,
   output logic              frame_done
);

   localparam int unsigned CW = (OUT_COLS    > 1) ? $clog2(OUT_COLS)    : 1;
   localparam int unsigned SW = (OUT_STRIPES > 1) ? $clog2(OUT_STRIPES) : 1;

   localparam logic [CW-1:0]     LAST_COL    = CW'(OUT_COLS - 1);
   localparam logic [SW-1:0]     LAST_STRIPE = SW'(OUT_STRIPES - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP    = ADDR_W'(OUT_COLS);
   // From column (C-1) row 0 of one stripe to column 0 row 0 of the next:
   // -(C-1) + 7*C = 6*C + 1
   localparam logic [ADDR_W-1:0] STRIPE_STEP = ADDR_W'(6 * OUT_COLS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [55:0]       r_mem [0:1];
   logic              r_wptr;
   logic              r_rptr;
   logic [1:0]        r_count;
   logic [1:0]        w_count_nxt;

   logic [2:0]        r_k;
   logic [CW-1:0]     r_col;
   logic [SW-1:0]     r_stripe;
   logic [ADDR_W-1:0] r_addr;      // address of the current (stripe, col, k)
   logic [ADDR_W-1:0] r_col_addr;  // address of the current (stripe, col, 0)

   logic [55:0]       w_col_in;
   logic [55:0]       w_head;
   logic              w_push;
   logic              w_ack;
   logic              w_pop;
   logic              w_last_col;
   logic              w_frame_end;

   always_comb begin
      w_col_in = '0;
      for (int unsigned k = 0; k < 7; k++) begin
         w_col_in[8*k +: 8] = gauss_in[k];
      end
   end

   assign w_head      = r_mem[r_rptr];
   assign w_push      = gauss_valid && (r_count < 2'd2);
   assign w_ack       = (r_state == S_WRITE) && sram_wr_ack;
   assign w_pop       = w_ack && (r_k == 3'd6);
   assign w_last_col  = (r_col == LAST_COL);
   assign w_frame_end = w_pop && w_last_col && (r_stripe == LAST_STRIPE);

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + 2'd1;
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - 2'd1;
      end
   end

   // Next state and outputs
   always_comb begin
      w_state_nxt = r_state;
      gauss_ready = (r_count < 2'd2);
      sram_wr_en  = 1'b0;
      sram_addr   = '0;
      sram_wdata  = '0;
      frame_done  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (r_count != 2'd0) begin
               w_state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            sram_wr_en = 1'b1;
            sram_addr  = r_addr;
            sram_wdata = w_head[{r_k, 3'b000} +: 8];
            if (w_pop) begin
               // A push landing on the same edge as the pop keeps the
               // stream going without a bubble.
               if (w_frame_end) begin
                  w_state_nxt = S_DONE;
               end else if (w_count_nxt != 2'd0) begin
                  w_state_nxt = S_WRITE;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_DONE: begin
            frame_done  = 1'b1;
            w_state_nxt = (r_count != 2'd0) ? S_WRITE : S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Column storage carries no reset; validity is tracked by r_count
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_col_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_wptr     <= 1'b0;
         r_rptr     <= 1'b0;
         r_k        <= '0;
         r_col      <= '0;
         r_stripe   <= '0;
         r_addr     <= BASE_ADDR;
         r_col_addr <= BASE_ADDR;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         if (w_push) begin
            r_wptr <= ~r_wptr;
         end
         if (w_ack) begin
            if (r_k != 3'd6) begin
               r_k    <= r_k + 3'd1;
               r_addr <= r_addr + ROW_STEP;
            end else begin
               r_k    <= '0;
               r_rptr <= ~r_rptr;
               // Position wraps to (0,0) here already at the last byte of
               // the frame, so the DONE cycle has nothing left to clear.
               if (w_last_col) begin
                  r_col <= '0;
                  if (r_stripe == LAST_STRIPE) begin
                     r_stripe   <= '0;
                     r_addr     <= BASE_ADDR;
                     r_col_addr <= BASE_ADDR;
                  end else begin
                     r_stripe   <= r_stripe + SW'(1);
                     r_addr     <= r_col_addr + STRIPE_STEP;
                     r_col_addr <= r_col_addr + STRIPE_STEP;
                  end
               end else begin
                  r_col      <= r_col + CW'(1);
                  r_addr     <= r_col_addr + ADDR_W'(1);
                  r_col_addr <= r_col_addr + ADDR_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_gauss_writeback.sv
// tb_gauss_writeback
//   Directed and random stimulus for gauss_writeback with a small image
//   (4 columns, 2 stripes, base 0x0100). The reference model keeps a queue
//   of expected (address, byte) writes built from the raster formula for
//   every accepted column, and predicts ready / wr_en / frame_done each cycle.
module tb_gauss_writeback;

   localparam int          C    = 4;
   localparam int          S    = 2;
   localparam logic [15:0] BASE = 16'h0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        gauss_valid;
   logic [7:0]  gin [0:6];
   logic        gauss_ready;
   logic        sram_wr_en;
   logic [15:0] sram_addr;
   logic [7:0]  sram_wdata;
   logic        sram_wr_ack;
   logic        frame_done;

   gauss_writeback #(
      .ADDR_W     (16),
      .OUT_COLS   (C),
      .OUT_STRIPES(S),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .gauss_valid(gauss_valid),
      .gauss_in   (gin),
      .gauss_ready(gauss_ready),
      .sram_wr_en (sram_wr_en),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_wr_ack(sram_wr_ack),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;

   // Model: {frame_last, addr[15:0], data[7:0]} per expected write
   logic [24:0] q [$];
   int unsigned col_idx     = 0;
   bit          prev_ne     = 1'b0;
   bit          done_due    = 1'b0;
   int          dut_acks    = 0;
   int          done_pulses = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [55:0] mk_col(input int unsigned b);
      logic [55:0] r;
      r = '0;
      for (int k = 0; k < 7; k++) r[8*k +: 8] = 8'(b + k);
      return r;
   endfunction

   task automatic add_col(input logic [55:0] d);
      int unsigned stripe;
      int unsigned col;
      logic [15:0] a;
      bit          last;
      stripe = (col_idx / C) % S;
      col    = col_idx % C;
      for (int k = 0; k < 7; k++) begin
         a    = BASE + 16'((stripe * 7 + k) * C + col);
         last = (k == 6) && (stripe == S - 1) && (col == C - 1);
         q.push_back({last, a, d[8*k +: 8]});
      end
      col_idx++;
   endtask

   // One clock: check outputs against the model, drive inputs, advance model
   task automatic cyc(input bit r, input bit v, input logic [55:0] d, input bit a);
      bit ne_now;
      bit exp_wr;
      bit exp_rdy;
      bit popped_last;
      bit obs_wr;
      ne_now  = (q.size() > 0);
      exp_wr  = ne_now && prev_ne && !done_due;
      exp_rdy = ((q.size() + 6) / 7) < 2;
      chk("wr_en", 32'(sram_wr_en), 32'(exp_wr));
      chk("ready", 32'(gauss_ready), 32'(exp_rdy));
      chk("frame_done", 32'(frame_done), 32'(done_due));
      if (exp_wr) begin
         chk("addr", 32'(sram_addr), 32'(q[0][23:8]));
         chk("wdata", 32'(sram_wdata), 32'(q[0][7:0]));
      end
      if (frame_done === 1'b1) done_pulses++;
      obs_wr = (sram_wr_en === 1'b1);

      rst         = r;
      gauss_valid = v;
      for (int k = 0; k < 7; k++) gin[k] = d[8*k +: 8];
      sram_wr_ack = a;
      @(posedge clk);

      if (obs_wr && a && !r) dut_acks++;
      popped_last = 1'b0;
      if (r) begin
         q.delete();
         col_idx = 0;
         prev_ne = 1'b0;
      end else begin
         prev_ne = ne_now;
         if (exp_wr && a) begin
            popped_last = q[0][24];
            void'(q.pop_front());
         end
         if (v && exp_rdy) add_col(d);
      end
      done_due = popped_last;
      @(negedge clk);
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, '0, 1'b0);
      cyc(1'b1, 1'b0, '0, 1'b0);
   endtask

   initial begin
      int          acks0;
      int          pulses0;
      int          acc;
      bit          will;
      logic [63:0] rnd;
      logic [55:0] d;

      rst         = 1'b1;
      gauss_valid = 1'b0;
      sram_wr_ack = 1'b0;
      for (int k = 0; k < 7; k++) gin[k] = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state
      chk("rst_ready", 32'(gauss_ready), 32'd1);
      chk("rst_wr_en", 32'(sram_wr_en), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_wdata", 32'(sram_wdata), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);

      // 1: single column, ack held high
      acks0 = dut_acks;
      cyc(1'b0, 1'b1, mk_col(10), 1'b1);
      chk("t1_latency_idle", 32'(sram_wr_en), 32'd0);
      cyc(1'b0, 1'b0, '0, 1'b1);
      chk("t1_first_wr", 32'(sram_wr_en), 32'd1);
      chk("t1_first_addr", 32'(sram_addr), 32'h0100);
      chk("t1_first_data", 32'(sram_wdata), 32'd10);
      repeat (10) cyc(1'b0, 1'b0, '0, 1'b1);
      chk("t1_ready", 32'(gauss_ready), 32'd1);
      chk("t1_writes", 32'(dut_acks - acks0), 32'd7);

      // 2: ack stall on k=2
      do_reset();
      cyc(1'b0, 1'b1, mk_col(10), 1'b1);
      repeat (3) cyc(1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, '0, 1'b0);
         chk("t2_hold_addr", 32'(sram_addr), 32'h0108);
         chk("t2_hold_data", 32'(sram_wdata), 32'd12);
      end
      repeat (8) cyc(1'b0, 1'b0, '0, 1'b1);

      // 3: full buffer, third column refused
      do_reset();
      cyc(1'b0, 1'b1, mk_col(32), 1'b0);
      cyc(1'b0, 1'b1, mk_col(48), 1'b0);
      chk("t3_ready_full", 32'(gauss_ready), 32'd0);
      cyc(1'b0, 1'b1, mk_col(64), 1'b0);
      acks0 = dut_acks;
      repeat (20) cyc(1'b0, 1'b0, '0, 1'b1);
      chk("t3_writes", 32'(dut_acks - acks0), 32'd14);

      // 4: whole frame, then wrap to the next frame
      do_reset();
      pulses0 = done_pulses;
      acc     = 0;
      for (int i = 0; i < 200 && !(acc == 8 && q.size() == 0); i++) begin
         rnd  = {$urandom(), $urandom()};
         will = (acc < 8) && (((q.size() + 6) / 7) < 2);
         cyc(1'b0, acc < 8, rnd[55:0], 1'b1);
         if (will) acc++;
      end
      chk("t4_accepted", 32'(acc), 32'd8);
      repeat (2) cyc(1'b0, 1'b0, '0, 1'b1);
      chk("t4_done_pulses", 32'(done_pulses - pulses0), 32'd1);
      cyc(1'b0, 1'b1, mk_col(200), 1'b1);
      cyc(1'b0, 1'b0, '0, 1'b1);
      chk("t4_wrap_wr", 32'(sram_wr_en), 32'd1);
      chk("t4_wrap_addr", 32'(sram_addr), 32'h0100);
      repeat (8) cyc(1'b0, 1'b0, '0, 1'b1);

      // 5: reset mid-column with two entries buffered
      do_reset();
      cyc(1'b0, 1'b1, mk_col(80), 1'b1);
      cyc(1'b0, 1'b1, mk_col(96), 1'b1);
      repeat (3) cyc(1'b0, 1'b0, '0, 1'b1);
      chk("t5_k3_addr", 32'(sram_addr), 32'h010C);
      cyc(1'b1, 1'b0, '0, 1'b0);
      chk("t5_rst_wr_en", 32'(sram_wr_en), 32'd0);
      chk("t5_rst_ready", 32'(gauss_ready), 32'd1);
      cyc(1'b0, 1'b1, mk_col(112), 1'b1);
      cyc(1'b0, 1'b0, '0, 1'b1);
      chk("t5_restart_addr", 32'(sram_addr), 32'h0100);
      chk("t5_restart_data", 32'(sram_wdata), 32'd112);
      repeat (8) cyc(1'b0, 1'b0, '0, 1'b1);

      // 6: random traffic, overlapping push/pop, several frames
      do_reset();
      pulses0 = done_pulses;
      repeat (600) begin
         rnd = {$urandom(), $urandom()};
         d   = rnd[55:0];
         cyc(1'b0, $urandom_range(0, 1) == 1, d, $urandom_range(0, 9) < 7);
      end
      repeat (30) cyc(1'b0, 1'b0, '0, 1'b1);
      chk("t6_drained_idle", 32'(sram_wr_en), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
